ram_arbiter: RTL

- Shares one single-port synchronous RAM (8-bit data, 16-bit address) between NUM_REQ requesters.
- The RAM has an active-low write enable and samples on the falling clock edge.
- The block performs round-robin grant with a valid/ready handshake, drives registered RAM port signals, and returns read data to the originating requester after a fixed latency.
- It sits between client blocks (CPU/DMA/stack logic) and the RAM instance.

---
 rtl/ram_arb_pkg.sv | 17 +
 rtl/ram_arb_rr.sv | 54 +++++
 rtl/ram_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the RAM arbiter.
// Optional build macro RAM_ARB_FIXED_PRIO_EN selects fixed-priority grant.
package ram_arb_pkg;

  localparam int RD_LAT_DEF = 2;
  localparam int MAX_ID_W   = 3;

  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } pipe_entry_t;

endpackage

// File: rtl/ram_arb_rr.sv
// Combinational grant: rotating priority after i_ptr, or lowest index first
// when RAM_ARB_FIXED_PRIO_EN is defined.
module ram_arb_rr
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDW    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [IDW-1:0]     i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDW-1:0]     o_idx,
  output logic               o_any
);

`ifdef RAM_ARB_FIXED_PRIO_EN
  logic w_unused_ptr;
  assign w_unused_ptr = ^i_ptr;

  // Walk from the highest index down so the lowest valid index is written last.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_valid[k]) begin
        o_grant    = '0;
        o_grant[k] = 1'b1;
        o_idx      = IDW'(k);
        o_any      = 1'b1;
      end
    end
  end
`else
  // Walk offsets from farthest to nearest so the first hit after i_ptr wins.
  always_comb begin
    int j;
    j       = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      j = (int'(i_ptr) + k) % NUM_REQ;
      if (i_valid[IDW'(j)]) begin
        o_grant           = '0;
        o_grant[IDW'(j)]  = 1'b1;
        o_idx             = IDW'(j);
        o_any             = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Shares one negedge-sampled single-port RAM between NUM_REQ requesters.
// Define RAM_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int RD_LAT     = RD_LAT_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_din,
  output logic                          ram_we_n,
  input  logic [DATA_WIDTH-1:0]         ram_dout,
  output logic                          busy
);

  localparam int IDW = id_width(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("ram_arbiter: NUM_REQ must be in 2..8");
  end

  logic [NUM_REQ-1:0]    w_grant;
  logic [IDW-1:0]        w_idx;
  logic                  w_any;
  logic [IDW-1:0]        w_ptr;
  logic                  w_xfer;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;

  logic                  r_we_n;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_din;
  logic [NUM_REQ-1:0]    r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  pipe_entry_t           r_pipe [RD_LAT];

`ifdef RAM_ARB_FIXED_PRIO_EN
  assign w_ptr = IDW'(NUM_REQ - 1);
`else
  logic [IDW-1:0] r_ptr;
  assign w_ptr = r_ptr;

  always_ff @(posedge clk) begin
    if (rst)         r_ptr <= IDW'(NUM_REQ - 1);
    else if (w_xfer) r_ptr <= w_idx;
  end
`endif

  ram_arb_rr #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_valid (req_valid),
    .i_ptr   (w_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign req_ready = rst ? '0 : w_grant;
  assign w_xfer    = w_any & ~rst;

  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_we    = req_we[i];
        w_sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Issue stage: RAM port registers and the read-return shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we_n      <= 1'b1;
      r_addr      <= '0;
      r_din       <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      for (int i = 0; i < RD_LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_we_n <= ~(w_xfer & w_sel_we);
      if (w_xfer) begin
        r_addr <= w_sel_addr;
        r_din  <= w_sel_wdata;
      end
      r_pipe[0] <= '{valid: w_xfer & ~w_sel_we, id: MAX_ID_W'(w_idx)};
      for (int i = 1; i < RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
      // Return stage: the oldest entry lines up with ram_dout.
      r_rsp_valid <= r_pipe[RD_LAT-1].valid ? (NUM_REQ'(1) << r_pipe[RD_LAT-1].id) : '0;
      if (r_pipe[RD_LAT-1].valid) r_rsp_data <= ram_dout;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < RD_LAT; i++) busy = busy | r_pipe[i].valid;
  end

  assign ram_we_n  = r_we_n;
  assign ram_addr  = r_addr;
  assign ram_din   = r_din;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

endmodule
